// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Optional feature macro: DCACHE_PERF_CNT_EN (hit/miss counters on dcache_ctrl).
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dcache_state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = 128;
    localparam int OFF_W          = 2;

    // Word offset inside a line.
    function automatic logic [1:0] addr_offset(input logic [31:0] addr);
        return addr[1:0];
    endfunction

    // Line index, right-aligned; caller truncates to its index width.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
        return (addr >> OFF_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag, right-aligned; caller truncates to its tag width.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
        return addr >> (OFF_W + idx_w);
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/state/data storage for the data cache: combinational read of one line,
// a single-word write port, a whole-line fill port and a synchronous clear.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [1:0]        wr_off,
    input  logic [31:0]       wr_word,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Line state: a fill makes a line valid and clean, a word write makes it dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage.
    // NOTE: no reset here on purpose -- contents are only trusted when valid is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_data;
        end else if (wr_en) begin
            data_q[idx][{wr_off, 5'b0} +: 32] <= wr_word;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete with no stall; misses write back a dirty victim, then refill.
// Optional feature macro: DCACHE_PERF_CNT_EN adds hit_cnt / miss_cnt outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int ADDR_W    = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [31:0]         proc_wdata,
    output logic [31:0]         proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   mem_rdata,
    input  logic                mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    dcache_state_t     state;
    logic [31:0]       addr_ext;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        off;
    logic              line_valid;
    logic              line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              req;
    logic              hit;
    logic              idle_req;
    logic              wr_hit;
    logic              fill;

    assign addr_ext = 32'(proc_addr);
    assign idx      = IDX_W'(addr_index(addr_ext, IDX_W));
    assign tag      = TAG_W'(addr_tag(addr_ext, IDX_W));
    assign off      = addr_offset(addr_ext);

    assign req      = proc_read | proc_write;
    assign hit      = line_valid && (line_tag == tag);
    assign idle_req = !rst && (state == IDLE) && req;
    // A simultaneous read and write is served as a write.
    assign wr_hit   = idle_req && proc_write && hit;
    assign fill     = !rst && (state == ALLOCATE) && mem_ready;

    assign proc_stall = !rst && ((state != IDLE) || (req && !hit));
    assign proc_rdata = (idle_req && proc_read && hit) ? line_data[{off, 5'b0} +: 32] : 32'd0;

    dcache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_en     (wr_hit),
        .wr_off    (off),
        .wr_word   (proc_wdata),
        .fill_en   (fill),
        .fill_tag  (tag),
        .fill_data (mem_rdata)
    );

    // Miss FSM; memory-side outputs are registered so they are pure functions of state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        if (line_valid && line_dirty) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= {line_tag, idx};
                            mem_wdata <= line_data;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                            mem_addr <= proc_addr[ADDR_W-1:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= proc_addr[ADDR_W-1:2];
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        mem_read <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Performance counters: zero-stall completions and misses leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (idle_req) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expected processor
// completions and memory transactions; monitors pop and compare.
module tb_dcache_ctrl;

    localparam int ADDR_W = 30;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } proc_exp_t;

    typedef struct {
        logic         is_write;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } mem_exp_t;

    logic              clk;
    logic              rst;
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [27:0]       mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;
`endif

    proc_exp_t proc_q[$];
    mem_exp_t  mem_q[$];
    proc_exp_t pe;
    mem_exp_t  me;

    int n_cmp      = 0;
    int n_bad      = 0;
    int n_mem_txn  = 0;
    int exp_hits   = 0;
    int exp_misses = 0;
    int lat        = 3;
    int rsp_cnt    = 0;
    logic prev_rd  = 1'b0;
    logic prev_wr  = 1'b0;

    dcache_ctrl #(.NUM_LINES(8), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: pulses mem_ready in the lat-th cycle of each request.
    // Refill word i of block b is 0xB000_0000 | (b << 4) | i.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                rsp_cnt   = 0;
            end
            if (mem_read || mem_write) begin
                rsp_cnt++;
                if (rsp_cnt == lat) mem_ready = 1'b1;
            end else begin
                rsp_cnt = 0;
            end
            for (int i = 0; i < 4; i++)
                mem_rdata[32*i +: 32] = 32'hB000_0000 | (32'(mem_addr) << 4) | 32'(i);
        end
    end

    // Processor-side monitor: every zero-stall cycle with a request is a completion.
    always @(negedge clk) begin
        if (!rst && (proc_read || proc_write) && !proc_stall) begin
            if (proc_q.size() == 0) begin
                check("unexpected_completion", 128'(proc_q.size()), 128'd1);
            end else begin
                pe = proc_q.pop_front();
                check("completion_kind", 128'(proc_read && !proc_write), 128'(pe.is_read));
                if (pe.is_read) check("proc_rdata", 128'(proc_rdata), 128'(pe.data));
                exp_hits++;
            end
        end
    end

    // Memory-side monitor: each rising request is one new block transaction.
    always @(negedge clk) begin
        if (!rst && ((mem_read && !prev_rd) || (mem_write && !prev_wr))) begin
            n_mem_txn++;
            if (mem_q.size() == 0) begin
                check("unexpected_mem_txn", 128'(mem_q.size()), 128'd1);
            end else begin
                me = mem_q.pop_front();
                check("mem_kind", 128'(mem_write), 128'(me.is_write));
                check("mem_addr", 128'(mem_addr), 128'(me.addr));
                if (me.is_write) check("mem_wdata", mem_wdata, me.wdata);
            end
        end
        prev_rd = mem_read;
        prev_wr = mem_write;
    end

    // Holds one request until it completes; checks how many cycles it stalled.
    task automatic access(input logic rd, input logic wr, input logic [29:0] addr,
                          input logic [31:0] wd, input int exp_stalls, input string name);
        int stalls = 0;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        @(negedge clk);
        while (proc_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        check({name, "_stalls"}, 128'(stalls), 128'(exp_stalls));
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    task automatic push_rd(input logic [31:0] d);
        proc_q.push_back('{is_read: 1'b1, data: d});
    endtask

    task automatic push_wr();
        proc_q.push_back('{is_read: 1'b0, data: 32'd0});
    endtask

    task automatic push_mem(input logic w, input logic [27:0] a, input logic [127:0] d);
        mem_q.push_back('{is_write: w, addr: a, wdata: d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, no request.
        @(negedge clk);
        check("rst_mem_read",   128'(mem_read),   128'd0);
        check("rst_mem_write",  128'(mem_write),  128'd0);
        check("rst_mem_addr",   128'(mem_addr),   128'd0);
        check("rst_mem_wdata",  mem_wdata,        128'd0);
        check("rst_proc_stall", 128'(proc_stall), 128'd0);
        check("rst_proc_rdata", 128'(proc_rdata), 128'd0);
        @(posedge clk);
        #1;

        // Clean miss, latency 3: stall = 1 + 3.
        push_mem(1'b0, 28'h4, '0);
        push_rd(32'hB000_0040);
        exp_misses++;
        access(1'b1, 1'b0, 30'h10, 32'd0, 4, "rd_0x10_miss");

        // Hits on the freshly filled line: no stall, no memory traffic.
        t0 = n_mem_txn;
        push_rd(32'hB000_0042);
        access(1'b1, 1'b0, 30'h12, 32'd0, 0, "rd_0x12_hit");
        push_wr();
        access(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF, 0, "wr_0x11_hit");
        push_rd(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 30'h11, 32'd0, 0, "rd_0x11_hit");
        check("hits_no_mem_traffic", 128'(n_mem_txn - t0), 128'd0);

        // Dirty conflict miss: writeback of block 0x4, refill block 0xC.
        push_mem(1'b1, 28'h4, {32'hB000_0043, 32'hB000_0042, 32'hDEAD_BEEF, 32'hB000_0040});
        push_mem(1'b0, 28'hC, '0);
        push_wr();
        exp_misses++;
        access(1'b0, 1'b1, 30'h31, 32'h1234_5678, 7, "wr_0x31_dirty_miss");
        push_rd(32'h1234_5678);
        access(1'b1, 1'b0, 30'h31, 32'd0, 0, "rd_0x31_hit");
        push_rd(32'hB000_00C3);
        access(1'b1, 1'b0, 30'h33, 32'd0, 0, "rd_0x33_hit");

        // Read and write together behave as a write.
        push_wr();
        access(1'b1, 1'b1, 30'h32, 32'hCAFE_F00D, 0, "rdwr_0x32_hit");
        push_rd(32'hCAFE_F00D);
        access(1'b1, 1'b0, 30'h32, 32'd0, 0, "rd_0x32_hit");

        // Reset during ALLOCATE: request abandoned, lines invalidated.
        lat = 10;
        push_mem(1'b0, 28'h0, '0);
        proc_read = 1'b1;
        proc_addr = 30'h00;
        for (int i = 0; i < 20 && !mem_read; i++) @(negedge clk);
        check("alloc_mem_read_seen", 128'(mem_read), 128'd1);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        proc_read  = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge clk);
        #1;
        check("rst_mid_mem_read",  128'(mem_read),  128'd0);
        check("rst_mid_mem_write", 128'(mem_write), 128'd0);
        rst = 1'b0;
        lat = 3;
        @(posedge clk);
        #1;

        // The dirty line at 0x10's index was dropped: clean miss, no writeback.
        push_mem(1'b0, 28'h4, '0);
        push_rd(32'hB000_0040);
        exp_misses++;
        access(1'b1, 1'b0, 30'h10, 32'd0, 4, "rd_0x10_after_rst");

        // Latency-1 clean miss: stall = 1 + 1.
        lat = 1;
        push_mem(1'b0, 28'hA, '0);
        push_rd(32'hB000_00A2);
        exp_misses++;
        access(1'b1, 1'b0, 30'h2A, 32'd0, 2, "rd_0x2A_lat1");

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("proc_q_drained", 128'(proc_q.size()), 128'd0);
        check("mem_q_drained",  128'(mem_q.size()),  128'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("hit_cnt",  128'(hit_cnt),  128'(exp_hits));
        check("miss_cnt", 128'(miss_cnt), 128'(exp_misses));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller. It is the responder on the pipeline's data-cache port: it accepts word-addressed reads and writes from the core's MEM stage and asserts `proc_stall` until the access can complete. On the other side it acts as the initiator on a 128-bit block memory bus. Hits complete with zero stall cycles; misses evict a dirty line first if needed, then refill.

## Interface
Parameters:
- `NUM_LINES`, 8: number of lines; must be a power of 2; index width `IDX_W = log2(NUM_LINES)`.
- `ADDR_W`, 30: processor word-address width; tag width `TAG_W = ADDR_W - 2 - IDX_W`.

Ports:
- Reset is synchronous and active-high; one clock.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `proc_read`  in  1  read request, held by the core while stalled.
- `proc_write`  in  1  write request, held by the core while stalled.
- `proc_addr`  in  ADDR_W  word address; bits [1:0] select the word, [IDX_W+1:2] the index, the rest the tag.
- `proc_wdata`  in  32  write data.
- `proc_rdata`  out  32  read data; valid when `proc_read` is high and `proc_stall` is low.
- `proc_stall`  out  1  high while the request cannot complete this cycle.
- `mem_read`  out  1  block read request.
- `mem_write`  out  1  block write request.
- `mem_addr`  out  ADDR_W-2  block address.
- `mem_wdata`  out  128  evicted line; word 0 is in bits [31:0].
- `mem_rdata`  in  128  refill line, same word order.
- `mem_ready`  in  1  one-cycle completion pulse for the current block transaction.

## Operation
- States:
  - `IDLE`: compare and serve.
  - `WRITEBACK`: evicting a line.
  - `ALLOCATE`: refilling a line.
- Per line: `valid`, `dirty`, `tag`, and 4×32 data.
- `IDLE`, request present (`proc_read | proc_write`):
  - Hit means valid and the tag matches.
  - Read hit: `proc_rdata` = the addressed word, combinationally. `proc_stall` = 0.
  - Write hit: the word is written at the edge and `dirty` is set. `proc_stall` = 0.
  - Miss: `proc_stall` = 1. If the line is valid and dirty, go to `WRITEBACK`; otherwise go to `ALLOCATE`.
- `WRITEBACK`:
  - `mem_write` = 1, `mem_addr` = {stored tag, index}, `mem_wdata` = line data.
  - On an edge with `mem_ready` = 1, go to `ALLOCATE`.
- `ALLOCATE`:
  - `mem_read` = 1, `mem_addr` = `proc_addr[ADDR_W-1:2]`.
  - On an edge with `mem_ready` = 1: line data = `mem_rdata`, `valid` = 1, `dirty` = 0, tag updated, go to `IDLE`.
  - The pending access is then re-evaluated as a hit in the following `IDLE` cycle.
- `proc_stall` = 1 in every cycle spent in `WRITEBACK` or `ALLOCATE`.
- `proc_read` and `proc_write` both high: treated as a write.
- No request: `proc_stall` = 0 and `proc_rdata` = 0.
- The core's request must stay stable while stalled. Changing it mid-miss is not supported.
- `mem_ready` outside `WRITEBACK`/`ALLOCATE` is ignored.

## Timing
- Reset values:
  - state `IDLE`; all `valid`/`dirty` = 0.
  - `mem_read` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `proc_stall` = 0, `proc_rdata` = 0.
- Data array contents are not reset.
- Memory outputs are Moore functions of state, so they assert the cycle after the miss is detected.
- They deassert in the cycle after the `mem_ready` edge.
- Memory outputs are held stable for the whole transaction.
- Clean miss with a memory latency of L cycles:
  - Stall cycles = 1 (detect) + L (`ALLOCATE`, including the `mem_ready` cycle).
  - Stall is low in the following `IDLE` cycle.
- Dirty miss: adds the `WRITEBACK` duration before `ALLOCATE`.
- Reset mid-transaction:
  - Returns to `IDLE` and drops `mem_read`/`mem_write` at the next edge.
  - Invalidates all lines.
  - The in-flight memory transaction is abandoned.

## Configuration
- `DCACHE_PERF_CNT_EN` defined: adds outputs `hit_cnt` and `miss_cnt`, each 32-bit, reset to 0, wrapping modulo 2^32.
  - `hit_cnt` increments on each zero-stall completed access.
  - `miss_cnt` increments once per miss, on leaving `IDLE`.
- `DCACHE_PERF_CNT_EN` undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- `dcache_pkg` holds:
  - the state enum `dcache_state_t` (`IDLE`, `WRITEBACK`, `ALLOCATE`);
  - `WORDS_PER_LINE` = 4 and `LINE_W` = 128;
  - field-extraction helpers for tag, index and offset.
- One sub-module, `dcache_line_array`, is natural:
  - valid/dirty/tag/data storage;
  - combinational read;
  - a word-write port and a line-fill port;
  - synchronous clear of valid/dirty.
- The FSM and hit logic stay in `dcache_ctrl`.

## Test plan
- After reset, read 0x10 with `mem_ready` pulsed 3 cycles after `mem_read` rises → `mem_addr` = 0x4, stall lasts 4 cycles, then stall low and `proc_rdata` = word 0 of the returned line.
- Read 0x12 immediately after that fill → `proc_stall` = 0 in the same cycle, `proc_rdata` = word 2, `mem_read` stays 0.
- Write 0xDEADBEEF to 0x11, then read 0x11 → both complete with no stall, the read returns 0xDEADBEEF, no memory traffic.
- With 0x11 dirty, write to 0x31 (same index, different tag) → `mem_write` with `mem_addr` = 0x4 and word 1 of `mem_wdata` = 0xDEADBEEF, then `mem_read` with `mem_addr` = 0xC, then the write hits.
- Assert `rst` while in `ALLOCATE` → `mem_read` = 0 on the next cycle, and a subsequent read of 0x10 misses again.
- With `DCACHE_PERF_CNT_EN`, run the sequence above → `hit_cnt` and `miss_cnt` match the scoreboard counts exactly.
